// File: rtl/pstats_evt_ser.sv
// Event serializer: per-line saturating pre-counters, drained one record at a
// time by a round-robin scan into a valid/ready stream of (port, counter, increment).
module pstats_evt_ser #(
  parameter int g_nports = 2,
  parameter int g_cnt_pp = 16,
  parameter int g_cnt_pw = 4,
  localparam int N   = g_nports * g_cnt_pp,
  localparam int W_P = (g_nports > 1) ? $clog2(g_nports) : 1,
  localparam int W_C = (g_cnt_pp > 1) ? $clog2(g_cnt_pp) : 1,
  localparam int W_I = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        events_i,
  output logic                upd_valid_o,
  input  logic                upd_ready_i,
  output logic [W_P-1:0]      upd_port_o,
  output logic [W_C-1:0]      upd_cnt_o,
  output logic [g_cnt_pw-1:0] upd_inc_o,
  output logic                drop_o,
  output logic                dbg_state_o
);

  // Record handshake: a record transfers on a rising edge where upd_valid_o and
  // upd_ready_i are both high; while valid is high the record fields hold still.
  typedef enum logic {ST_SCAN, ST_OFFER} state_t;

  localparam logic [g_cnt_pw-1:0] PC_MAX = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [g_cnt_pw-1:0] r_pc [N];
  logic [W_I-1:0]      r_idx;
  logic [W_I-1:0]      w_idx_nxt;
  logic [W_P-1:0]      r_port;
  logic [W_C-1:0]      r_cnt;
  logic [g_cnt_pw-1:0] r_inc;
  logic                r_drop;
  logic [g_cnt_pw-1:0] w_cur;
  logic                w_take;
  logic                w_hs;
  logic                w_adv;
  logic                w_drop;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_SCAN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_cur       = r_pc[r_idx];
    w_take      = (r_state == ST_SCAN) && (w_cur != '0);
    w_hs        = (r_state == ST_OFFER) && upd_ready_i;
    w_adv       = ((r_state == ST_SCAN) && !w_take) || w_hs;
    w_idx_nxt   = (r_idx == W_I'(N - 1)) ? '0 : r_idx + 1'b1;
    w_state_nxt = r_state;
    case (r_state)
      ST_SCAN:  if (w_take) w_state_nxt = ST_OFFER;
      ST_OFFER: if (w_hs)   w_state_nxt = ST_SCAN;
      default:              w_state_nxt = ST_SCAN;
    endcase
  end

  // The line being snapshotted takes this cycle's event as its new value, so it never saturates.
  always_comb begin
    w_drop = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (events_i[i] && (r_pc[i] == PC_MAX) && !(w_take && (r_idx == W_I'(i))))
        w_drop = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) r_pc[i] <= '0;
      r_idx  <= '0;
      r_port <= '0;
      r_cnt  <= '0;
      r_inc  <= '0;
      r_drop <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_take && (r_idx == W_I'(i)))
          r_pc[i] <= {{(g_cnt_pw-1){1'b0}}, events_i[i]};
        else if (events_i[i] && (r_pc[i] != PC_MAX))
          r_pc[i] <= r_pc[i] + 1'b1;
      end
      if (w_take) begin
        r_port <= W_P'(32'(r_idx) / g_cnt_pp);
        r_cnt  <= W_C'(32'(r_idx) % g_cnt_pp);
        r_inc  <= w_cur;
      end
      if (w_adv) r_idx <= w_idx_nxt;
      r_drop <= w_drop;
    end
  end

  assign upd_valid_o = (r_state == ST_OFFER);
  assign upd_port_o  = r_port;
  assign upd_cnt_o   = r_cnt;
  assign upd_inc_o   = r_inc;
  assign drop_o      = r_drop;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pstats_evt_ser.sv
// Directed and random checks of pstats_evt_ser with a record scoreboard and
// per-line conservation accounting.
module tb_pstats_evt_ser;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] events;
  logic        ready;
  logic        valid;
  logic [0:0]  port;
  logic [3:0]  cnt;
  logic [3:0]  inc;
  logic        drop;
  logic        dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int pulses[N];
  int acc[N];
  int drop_cnt = 0;
  int n_rec    = 0;
  bit chk_en   = 1'b0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  pstats_evt_ser dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .events_i    (events),
    .upd_valid_o (valid),
    .upd_ready_i (ready),
    .upd_port_o  (port),
    .upd_cnt_o   (cnt),
    .upd_inc_o   (inc),
    .drop_o      (drop),
    .dbg_state_o (dbg_state)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      pulses[i] = 0;
      acc[i]    = 0;
    end
    drop_cnt = 0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k;
    k = 0;
    while (!valid && k < max) begin
      tick();
      k++;
    end
    chk({tag, "_valid_timeout"}, int'(valid), 1);
  endtask

  // Monitor sits on the falling edge: what it sees is what the next rising edge captures.
  always @(negedge clk) begin
    logic [9:0] got_r;
    logic [9:0] exp_r;
    if (!rst) begin
      for (int i = 0; i < N; i++) if (events[i]) pulses[i]++;
      if (drop) drop_cnt++;
      if (valid && ready) begin
        acc[{port, cnt}] += int'(inc);
        n_rec++;
        if (chk_en) begin
          got_r = {1'b1, port, cnt, inc};
          exp_r = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : 10'h0;
          chk("record", int'(got_r), int'(exp_r));
        end
      end
    end
  end

  initial begin
    logic [0:0] h_port;
    logic [3:0] h_cnt;
    logic [3:0] h_inc;
    bit         stable;
    int         rec0;

    rst = 1'b1; events = '0; ready = 1'b1;
    clear_stats();
    ticks(2);
    chk("rst_valid", int'(valid), 0);
    chk("rst_inc", int'(inc), 0);
    rst = 1'b0;
    tick();
    chk("idle_valid", int'(valid), 0);
    chk("idle_port", int'(port), 0);
    chk("idle_cnt", int'(cnt), 0);
    chk("idle_drop", int'(drop), 0);

    // Single pulse on bit 17 -> exactly one record (port 1, cnt 1, inc 1).
    ticks(5);
    exp_q.push_back({1'b1, 4'd1, 4'd1});
    chk_en = 1'b1;
    rec0 = n_rec;
    events[17] = 1'b1; tick(); events = '0;
    ticks(64);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_rec_count", n_rec - rec0, 1);
    chk_en = 1'b0;

    // Bit 3 pulsed 5 times while the consumer stalls.
    clear_stats();
    ready = 1'b0;
    events[3] = 1'b1; ticks(5); events = '0;
    wait_valid("t2", 64);
    chk("t2_port", int'(port), 0);
    chk("t2_cnt", int'(cnt), 3);
    chk("t2_inc_range", int'(inc >= 4'd1 && inc <= 4'd5), 1);
    h_port = port; h_cnt = cnt; h_inc = inc;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!valid || port !== h_port || cnt !== h_cnt || inc !== h_inc) stable = 1'b0;
    end
    chk("t2_hold_stable", int'(stable), 1);
    ready = 1'b1;
    ticks(100);
    chk("t2_sum_bit3", acc[3], 5);

    // Park the scan on bit 1, then saturate bit 0 with 20 pulses.
    clear_stats();
    ready = 1'b0;
    events[1] = 1'b1; tick(); events = '0;
    wait_valid("t3", 64);
    chk("t3_park_cnt", int'(cnt), 1);
    events[0] = 1'b1; ticks(20); events = '0;
    ticks(3);
    chk("t3_drops", drop_cnt, 5);
    ready = 1'b1;
    ticks(100);
    chk("t3_sum_bit0", acc[0], 15);
    chk("t3_sum_bit1", acc[1], 1);
    chk("t3_conservation", acc[0] + drop_cnt, pulses[0]);

    // Event on bit 5 in the same cycle its count of 2 is snapshotted.
    clear_stats();
    ready = 1'b0;
    events[4] = 1'b1; tick(); events = '0;
    wait_valid("t4", 64);
    events[5] = 1'b1; ticks(2); events = '0;
    tick();
    exp_q.push_back({1'b0, 4'd4, 4'd1});
    exp_q.push_back({1'b0, 4'd5, 4'd2});
    exp_q.push_back({1'b0, 4'd5, 4'd1});
    chk_en = 1'b1;
    ready = 1'b1;
    tick();
    events[5] = 1'b1; tick(); events = '0;
    ticks(80);
    chk("t4_queue_empty", exp_q.size(), 0);
    chk("t4_sum_bit5", acc[5], 3);
    chk_en = 1'b0;

    // Reset while a record is offered; events during reset are ignored.
    ready = 1'b0;
    events[9] = 1'b1; tick(); events = '0;
    wait_valid("t5", 64);
    rst = 1'b1; events[2] = 1'b1; tick();
    rst = 1'b0; events = '0;
    chk("t5_valid_after_rst", int'(valid), 0);
    chk("t5_inc_after_rst", int'(inc), 0);
    chk_en = 1'b1;
    rec0 = n_rec;
    ready = 1'b1;
    ticks(80);
    chk("t5_no_records", n_rec - rec0, 0);
    chk_en = 1'b0;

    // Random traffic with random back-pressure, then drain.
    clear_stats();
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < N; b++) events[b] = ($urandom_range(0, 99) < 2);
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    events = '0;
    ready = 1'b1;
    ticks(300);
    chk("t6_no_drops", drop_cnt, 0);
    for (int b = 0; b < N; b++) chk($sformatf("t6_sum_bit%0d", b), acc[b], pulses[b]);
    chk("t6_idle_valid", int'(valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
